bec_operand_loader: RTL and testbench
=====================================

BEC_OPERAND_LOADER -- requirements
Module: bec_operand_loader

Interface
REQ-001 SHALL have parameters: FIELD_W, default 163, GF(2^163) operand width; WORD_W, default 32, bus word width; NWORDS, default 6, words per operand (ceil(FIELD_W/WORD_W)).
REQ-002 SHALL have ports, clock and reset first: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: wr_valid  in  1  write word offered; wr_ready  out  1  word accepted when both high at posedge clk.
REQ-004 SHALL have ports: wr_sel  in  3  operand index (0 w1, 1 z1, 2 w2, 3 z2, 4 inv_w0, 5 d, 6 key; 7 illegal); wr_data  in  WORD_W  operand word.
REQ-005 SHALL have ports: start  in  1  launch request; core_done  in  1  done from scalar-multiplier core; next_key  in  1  core request for the next key bit.
REQ-006 SHALL have ports: w1, z1, w2, z2, inv_w0, d  out  FIELD_W each  operand registers; ki  out  1  current key bit; core_enable  out  1  core run enable.
REQ-007 SHALL have ports: loaded  out  7  per-operand complete mask; busy  out  1  core running; done_pulse  out  1  one-cycle completion strobe; err  out  1  one-cycle protocol-error strobe.

Function
REQ-008 SHALL implement FSM states: LOAD, RUN, FINISH; LOAD is the reset state.
REQ-009 In LOAD, wr_ready SHALL be 1; in RUN and FINISH, wr_ready SHALL be 0.
REQ-010 An accepted word SHALL be written to the selected operand at bit offset WORD_W*word_idx in the same posedge; word_idx SHALL be an internal 3-bit counter.
REQ-011 Word order SHALL be LSW first; for word NWORDS-1, only bits [FIELD_W-1-160:0] (3 bits) SHALL be stored and the rest discarded.
REQ-012 After word NWORDS-1 is accepted: loaded[wr_sel] SHALL be set, and word_idx SHALL wrap to 0 on the same edge.
REQ-013 The first accepted word of an operand SHALL clear loaded[wr_sel], so that operand can be rewritten.
REQ-014 If wr_sel differs from the sel latched at word_idx 0 while word_idx != 0: word accepted as word 0 of the new sel, err pulses; the old operand's loaded bit SHALL stay 0.
REQ-015 An accepted word with wr_sel=7 SHALL be dropped, pulse err, and leave word_idx unchanged.
REQ-016 Operand 6 SHALL load a FIELD_W-bit key shift register; ki SHALL equal key_reg[0] at all times.
REQ-017 In LOAD, a start with loaded==7'h7F SHALL move to RUN on the next edge; a start with any loaded bit 0 SHALL be ignored and pulse err.
REQ-018 core_enable and busy SHALL be 1 exactly while in RUN, starting the cycle after start is sampled.
REQ-019 In RUN, on each cycle with next_key=1, key_reg SHALL shift right by 1 with zero fill.
REQ-020 A 8-bit shift counter SHALL increment on each shift; next_key arriving at count FIELD_W SHALL not shift and SHALL pulse err.
REQ-021 When core_done=1 in RUN, the FSM SHALL go to FINISH; if next_key is 1 in the same cycle, core_done SHALL win and no shift SHALL occur.
REQ-022 FINISH SHALL last one cycle: done_pulse=1, loaded cleared to 0, shift counter cleared, then the FSM SHALL return to LOAD.
REQ-023 Operand registers SHALL hold their values through RUN and FINISH; the core samples them continuously.
REQ-024 start outside LOAD SHALL be ignored without an err pulse.

Reset
REQ-025 On rst_n=0, asynchronously: state LOAD, all operands and key_reg 0, word_idx 0, counter 0, loaded 0, and core_enable, busy, done_pulse, err all 0.
REQ-026 Reset asserted mid-RUN SHALL drop core_enable immediately; no done_pulse SHALL follow.
REQ-027 wr_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.

Structure
REQ-028 A shared package bec_pkg SHALL hold FIELD_W, WORD_W, NWORDS, the operand-index constants, and the FSM state encoding.
REQ-029 One sub-module SHALL be used: bec_key_shifter, containing key_reg, the shift counter, and the overflow error; everything else is flat.

Verification
REQ-030 Load all 7 operands with words 0x1111_1111 ... word5=0x7 -> each operand = {3'h7,160'h1111...}, loaded=7'h7F after the 42nd word.
REQ-031 Load 6 operands only, then pulse start -> err pulse, state stays LOAD, core_enable=0.
REQ-032 Key = 163'h5, start, 3 next_key pulses -> ki sequence 1,0,1,0; core_done -> done_pulse one cycle later, loaded=0.
REQ-033 Write 2 words of w1, then a word with wr_sel=1 -> err pulse, loaded[0]=0, word accepted as z1 word 0.
REQ-034 core_done and next_key high in the same cycle -> key_reg unchanged, FINISH entered.
REQ-035 rst_n low during RUN after 10 shifts -> core_enable=0 asynchronously, all registers 0, no done_pulse.

Source files
------------

// File: rtl/bec_pkg.sv
// rtl/bec_pkg.sv - shared widths, operand indices and FSM encoding for the BEC operand loader
package bec_pkg;

    localparam int FIELD_W = 163;
    localparam int WORD_W  = 32;
    localparam int NWORDS  = 6;

    localparam logic [2:0] SEL_W1      = 3'd0;
    localparam logic [2:0] SEL_Z1      = 3'd1;
    localparam logic [2:0] SEL_W2      = 3'd2;
    localparam logic [2:0] SEL_Z2      = 3'd3;
    localparam logic [2:0] SEL_INV_W0  = 3'd4;
    localparam logic [2:0] SEL_D       = 3'd5;
    localparam logic [2:0] SEL_KEY     = 3'd6;
    localparam logic [2:0] SEL_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bec_key_shifter.sv
// rtl/bec_key_shifter.sv - scalar key register, shift counter and shift-overflow error
module bec_key_shifter #(
    parameter int FIELD_W = bec_pkg::FIELD_W,
    parameter int WORD_W  = bec_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ld_en,
    input  logic [2:0]        i_ld_idx,
    input  logic [WORD_W-1:0] i_ld_data,
    input  logic              i_run,
    input  logic              i_next_key,
    input  logic              i_core_done,
    input  logic              i_clr,
    output logic              o_ki,
    output logic              o_err
);

    localparam int CNT_W = 8;

    logic [FIELD_W-1:0] r_key;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_shift_req;
    logic               w_ovf;
    logic               w_shift;
    logic [FIELD_W-1:0] w_ld_bits;
    logic [FIELD_W-1:0] w_ld_mask;

    // core_done has priority over a simultaneous key request
    assign w_shift_req = i_run && i_next_key && !i_core_done;
    // every key bit already consumed: refuse the shift and flag it
    assign w_ovf       = w_shift_req && (r_cnt == CNT_W'(FIELD_W));
    assign w_shift     = w_shift_req && !w_ovf;

    // bits of the last word that fall beyond FIELD_W drop off in the truncation
    assign w_ld_bits = FIELD_W'({{FIELD_W{1'b0}}, i_ld_data} << (WORD_W * i_ld_idx));
    assign w_ld_mask = FIELD_W'({{FIELD_W{1'b0}}, {WORD_W{1'b1}}} << (WORD_W * i_ld_idx));

    // key register: word writes while loading, one-bit right shift per accepted key request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (i_ld_en) begin
            r_key <= (r_key & ~w_ld_mask) | w_ld_bits;
        end else if (w_shift) begin
            r_key <= {1'b0, r_key[FIELD_W-1:1]};
        end
    end

    // shift counter: counts consumed key bits, cleared when a run finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // one-cycle overflow strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_ovf;
        end
    end

    assign o_ki  = r_key[0];
    assign o_err = r_err;

endmodule

// File: rtl/bec_operand_loader.sv
// rtl/bec_operand_loader.sv - word-serial operand loader and run sequencer for the GF(2^163) scalar-multiplier core
module bec_operand_loader #(
    parameter int FIELD_W = bec_pkg::FIELD_W,
    parameter int WORD_W  = bec_pkg::WORD_W,
    parameter int NWORDS  = bec_pkg::NWORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_sel,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               start,
    input  logic               core_done,
    input  logic               next_key,
    output logic [FIELD_W-1:0] w1,
    output logic [FIELD_W-1:0] z1,
    output logic [FIELD_W-1:0] w2,
    output logic [FIELD_W-1:0] z2,
    output logic [FIELD_W-1:0] inv_w0,
    output logic [FIELD_W-1:0] d,
    output logic               ki,
    output logic               core_enable,
    output logic [6:0]         loaded,
    output logic               busy,
    output logic               done_pulse,
    output logic               err
);

    import bec_pkg::*;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_wr_ready;
    logic [2:0]         r_word_idx;
    logic [2:0]         r_cur_sel;
    logic [6:0]         r_loaded;
    logic               r_err;
    logic [FIELD_W-1:0] r_op [6];

    logic               w_accept;
    logic               w_illegal;
    logic               w_switch;
    logic               w_wr_en;
    logic               w_last;
    logic [2:0]         w_eff_idx;
    logic [FIELD_W-1:0] w_wr_bits;
    logic [FIELD_W-1:0] w_wr_mask;
    logic               w_start_err;
    logic               w_core_enable;
    logic               w_done_pulse;
    logic               w_key_err;
    logic               w_key_ld;
    logic               w_finish;

    // ready is registered so it stays low through reset and rises on the first edge after
    assign w_accept  = wr_valid && r_wr_ready;
    assign w_illegal = (wr_sel == SEL_ILLEGAL);
    // a different operand mid-load abandons the old one and restarts at word 0
    assign w_switch  = (r_word_idx != 3'd0) && (wr_sel != r_cur_sel);
    assign w_eff_idx = w_switch ? 3'd0 : r_word_idx;
    assign w_last    = (w_eff_idx == 3'(NWORDS - 1));
    assign w_wr_en   = w_accept && !w_illegal;
    assign w_key_ld  = w_wr_en && (wr_sel == SEL_KEY);
    assign w_finish  = (r_state == ST_FINISH);

    assign w_wr_bits = FIELD_W'({{FIELD_W{1'b0}}, wr_data} << (WORD_W * w_eff_idx));
    assign w_wr_mask = FIELD_W'({{FIELD_W{1'b0}}, {WORD_W{1'b1}}} << (WORD_W * w_eff_idx));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state and state-decoded outputs
    always_comb begin
        w_next_state  = r_state;
        w_core_enable = 1'b0;
        w_done_pulse  = 1'b0;
        w_start_err   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (start) begin
                    if (r_loaded == 7'h7F) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_start_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_core_enable = 1'b1;
                if (core_done) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done_pulse = 1'b1;
                w_next_state = ST_LOAD;
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // write-side ready follows the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ready <= 1'b0;
        end else begin
            r_wr_ready <= (w_next_state == ST_LOAD);
        end
    end

    // word position, active operand and per-operand completion mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_idx <= '0;
            r_cur_sel  <= '0;
            r_loaded   <= '0;
        end else if (w_finish) begin
            r_loaded <= '0;
        end else if (w_wr_en) begin
            if (w_eff_idx == 3'd0) begin
                r_cur_sel <= wr_sel;
            end
            if (w_last) begin
                r_word_idx       <= 3'd0;
                r_loaded[wr_sel] <= 1'b1;
            end else begin
                r_word_idx <= w_eff_idx + 3'd1;
                if (w_eff_idx == 3'd0) begin
                    r_loaded[wr_sel] <= 1'b0;
                end
            end
        end
    end

    // operand registers take the accepted word in place; held untouched outside LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_wr_en && (wr_sel == 3'(i))) begin
                    r_op[i] <= (r_op[i] & ~w_wr_mask) | w_wr_bits;
                end
            end
        end
    end

    // one-cycle protocol error strobe for illegal index, operand switch or premature start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_accept && (w_illegal || w_switch)) || w_start_err;
        end
    end

    bec_key_shifter #(
        .FIELD_W (FIELD_W),
        .WORD_W  (WORD_W)
    ) u_key_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ld_en     (w_key_ld),
        .i_ld_idx    (w_eff_idx),
        .i_ld_data   (wr_data),
        .i_run       (w_core_enable),
        .i_next_key  (next_key),
        .i_core_done (core_done),
        .i_clr       (w_finish),
        .o_ki        (ki),
        .o_err       (w_key_err)
    );

    assign wr_ready    = r_wr_ready;
    assign w1          = r_op[SEL_W1];
    assign z1          = r_op[SEL_Z1];
    assign w2          = r_op[SEL_W2];
    assign z2          = r_op[SEL_Z2];
    assign inv_w0      = r_op[SEL_INV_W0];
    assign d           = r_op[SEL_D];
    assign loaded      = r_loaded;
    assign core_enable = w_core_enable;
    assign busy        = w_core_enable;
    assign done_pulse  = w_done_pulse;
    assign err         = r_err | w_key_err;

endmodule

// File: tb/tb_bec_operand_loader.sv
// tb/tb_bec_operand_loader.sv - directed and randomized self-checking bench for bec_operand_loader
module tb_bec_operand_loader;

    localparam int FW = 163;
    localparam int NW = 6;
    localparam logic [191:0] FMASK = {29'd0, {163{1'b1}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_sel = 3'd0;
    logic [31:0]   wr_data = 32'd0;
    logic          start = 1'b0;
    logic          core_done = 1'b0;
    logic          next_key = 1'b0;
    logic [FW-1:0] w1, z1, w2, z2, inv_w0, d;
    logic          ki;
    logic          core_enable;
    logic [6:0]    loaded;
    logic          busy;
    logic          done_pulse;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: operand images as plain word arrays, load progress, key consumption
    logic [191:0] m_buf [7];
    logic [6:0]   m_loaded;
    int           m_idx;
    logic [2:0]   m_sel;
    int           m_shifts;

    always #5 clk = ~clk;

    bec_operand_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .start       (start),
        .core_done   (core_done),
        .next_key    (next_key),
        .w1          (w1),
        .z1          (z1),
        .w2          (w2),
        .z2          (z2),
        .inv_w0      (inv_w0),
        .d           (d),
        .ki          (ki),
        .core_enable (core_enable),
        .loaded      (loaded),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] dut_op(input int s);
        case (s)
            0: return w1;
            1: return z1;
            2: return w2;
            3: return z2;
            4: return inv_w0;
            5: return d;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset;
        for (int s = 0; s < 7; s++) m_buf[s] = '0;
        m_loaded = '0;
        m_idx    = 0;
        m_sel    = 3'd0;
        m_shifts = 0;
    endtask

    task automatic do_reset;
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        model_reset();
        chk("post_reset_ready", wr_ready, 1'b1);
    endtask

    task automatic write_word(input logic [2:0] sel, input logic [31:0] data);
        logic exp_err;
        chk("wr_ready_before_write", wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        exp_err  = 1'b0;
        if (sel == 3'd7) begin
            exp_err = 1'b1;
        end else begin
            if (m_idx != 0 && sel != m_sel) begin
                exp_err = 1'b1;
                m_idx   = 0;
            end
            if (m_idx == 0) begin
                m_sel = sel;
                m_loaded[sel] = 1'b0;
            end
            m_buf[sel][32*m_idx +: 32] = data;
            m_buf[sel] = m_buf[sel] & FMASK;
            m_idx++;
            if (m_idx == NW) begin
                m_loaded[sel] = 1'b1;
                m_idx = 0;
            end
        end
        chk("wr_err", err, exp_err);
        chk("wr_loaded", loaded, m_loaded);
    endtask

    task automatic load_random(input logic [2:0] sel);
        for (int w = 0; w < NW; w++) write_word(sel, $urandom);
    endtask

    task automatic load_all_random;
        for (int s = 0; s < 7; s++) load_random(3'(s));
    endtask

    task automatic check_ops;
        for (int s = 0; s < 6; s++) chk($sformatf("operand%0d", s), dut_op(s), m_buf[s][FW-1:0]);
        chk("ki_vs_key", ki, m_buf[6][0]);
    endtask

    task automatic do_start;
        logic ok;
        ok = (m_loaded == 7'h7F);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_core_enable", core_enable, ok);
        chk("start_busy", busy, ok);
        chk("start_err", err, !ok);
        chk("start_wr_ready", wr_ready, !ok);
        chk("start_ki", ki, m_buf[6][0]);
    endtask

    task automatic run_cycle(input logic nk, input logic cd);
        logic exp_err;
        next_key  = nk;
        core_done = cd;
        tick();
        next_key  = 1'b0;
        core_done = 1'b0;
        exp_err   = 1'b0;
        if (!cd && nk) begin
            if (m_shifts < FW) begin
                m_buf[6] = m_buf[6] >> 1;
                m_shifts++;
            end else begin
                exp_err = 1'b1;
            end
        end
        chk("run_ki", ki, m_buf[6][0]);
        chk("run_err", err, exp_err);
        chk("run_done_pulse", done_pulse, cd);
        chk("run_core_enable", core_enable, !cd);
        if (cd) begin
            tick();
            m_loaded = '0;
            m_shifts = 0;
            chk("finish_done_low", done_pulse, 1'b0);
            chk("finish_loaded_clear", loaded, 7'h00);
            chk("finish_wr_ready", wr_ready, 1'b1);
            chk("finish_core_enable", core_enable, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach summary in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] k30;
        logic [2:0]    rsel;
        int            r;
        logic          seq [3];

        model_reset();

        // reset state while rst_n is held low
        #2;
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_loaded", loaded, 7'h00);
        chk("rst_core_enable", core_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_pulse", done_pulse, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_w1", w1, '0);
        chk("rst_d", d, '0);
        chk("rst_ki", ki, 1'b0);
        #4 rst_n = 1'b1;
        tick();
        chk("first_edge_ready", wr_ready, 1'b1);

        // all seven operands from the fixed word pattern
        k30 = {3'h7, {5{32'h1111_1111}}};
        for (int s = 0; s < 7; s++) begin
            for (int w = 0; w < NW - 1; w++) write_word(3'(s), 32'h1111_1111);
            write_word(3'(s), 32'h0000_0007);
        end
        chk("pattern_loaded_all", loaded, 7'h7F);
        for (int s = 0; s < 6; s++) chk($sformatf("pattern_op%0d", s), dut_op(s), k30);
        chk("pattern_ki", ki, 1'b1);
        check_ops();

        // start refused with one operand missing
        do_reset();
        for (int s = 0; s < 6; s++) load_random(3'(s));
        do_start();
        chk("partial_start_stays_load", core_enable, 1'b0);
        tick();
        chk("partial_start_err_one_cycle", err, 1'b0);

        // operand switch after two words of w1
        write_word(3'd0, $urandom);
        write_word(3'd0, $urandom);
        write_word(3'd1, 32'hCAFE_F00D);
        chk("switch_w1_not_loaded", loaded[0], 1'b0);
        for (int w = 1; w < NW; w++) write_word(3'd1, $urandom);
        chk("switch_z1_loaded", loaded[1], 1'b1);
        chk("switch_z1_word0", z1[31:0], 32'hCAFE_F00D);

        // key = 5, interrupted by an illegal index that must be dropped
        write_word(3'd6, 32'h5);
        write_word(3'd6, 32'h0);
        write_word(3'd6, 32'h0);
        write_word(3'd7, 32'hDEAD_BEEF);
        for (int w = 3; w < NW; w++) write_word(3'd6, 32'h0);
        chk("illegal_key_loaded", loaded[6], 1'b1);
        load_random(3'd0);
        chk("rebuilt_loaded_all", loaded, 7'h7F);

        // key bits delivered LSB first, start ignored during RUN, then finish
        do_start();
        chk("key5_ki0", ki, 1'b1);
        start = 1'b1;
        run_cycle(1'b0, 1'b0);
        start = 1'b0;
        seq[0] = 1'b0;
        seq[1] = 1'b1;
        seq[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 1'b0);
            chk($sformatf("key5_ki%0d", i + 1), ki, seq[i]);
        end
        check_ops();
        run_cycle(1'b0, 1'b1);

        // core_done beats a simultaneous key request
        load_all_random();
        do_start();
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b1);

        // every key bit consumed, then one request too many
        load_all_random();
        do_start();
        for (int i = 0; i < FW; i++) run_cycle(1'b1, 1'b0);
        chk("all_shifted_ki", ki, 1'b0);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b0, 1'b1);

        // randomized write traffic with switches and illegal indices
        do_reset();
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) rsel = (m_idx == 0) ? 3'($urandom_range(0, 6)) : m_sel;
            else       rsel = 3'($urandom_range(0, 7));
            write_word(rsel, $urandom);
        end
        check_ops();
        while (m_idx != 0) write_word(m_sel, $urandom);
        for (int s = 0; s < 7; s++) if (!m_loaded[s]) load_random(3'(s));
        do_start();
        for (int n = 0; n < 40; n++) run_cycle(1'($urandom_range(0, 1)), 1'b0);
        check_ops();
        run_cycle(1'($urandom_range(0, 1)), 1'b1);

        // reset in the middle of a run
        load_all_random();
        do_start();
        for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_core_enable", core_enable, 1'b0);
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_loaded", loaded, 7'h00);
        chk("midrun_rst_w1", w1, '0);
        chk("midrun_rst_inv_w0", inv_w0, '0);
        chk("midrun_rst_ki", ki, 1'b0);
        chk("midrun_rst_wr_ready", wr_ready, 1'b0);
        chk("midrun_rst_err", err, 1'b0);
        core_done = 1'b1;
        #4 rst_n = 1'b1;
        tick();
        core_done = 1'b0;
        model_reset();
        chk("midrun_rst_no_done", done_pulse, 1'b0);
        chk("midrun_rst_ready", wr_ready, 1'b1);
        chk("midrun_rst_idle", core_enable, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
